// File: rtl/adam_axil_pause_drain.sv
// AXI-Lite pause/drain gate: zero-latency pass-through with an outstanding-transaction
// limit. On pause it stops admitting new requests and acknowledges once all in-flight ones complete.
module adam_axil_pause_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_TRANS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause_req,
    output logic                    pause_ack,

    input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
    input  logic [2:0]              slv_aw_prot,
    input  logic                    slv_aw_valid,
    output logic                    slv_aw_ready,
    input  logic [DATA_WIDTH-1:0]   slv_w_data,
    input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
    input  logic                    slv_w_valid,
    output logic                    slv_w_ready,
    output logic [1:0]              slv_b_resp,
    output logic                    slv_b_valid,
    input  logic                    slv_b_ready,
    input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
    input  logic [2:0]              slv_ar_prot,
    input  logic                    slv_ar_valid,
    output logic                    slv_ar_ready,
    output logic [DATA_WIDTH-1:0]   slv_r_data,
    output logic [1:0]              slv_r_resp,
    output logic                    slv_r_valid,
    input  logic                    slv_r_ready,

    output logic [ADDR_WIDTH-1:0]   mst_aw_addr,
    output logic [2:0]              mst_aw_prot,
    output logic                    mst_aw_valid,
    input  logic                    mst_aw_ready,
    output logic [DATA_WIDTH-1:0]   mst_w_data,
    output logic [DATA_WIDTH/8-1:0] mst_w_strb,
    output logic                    mst_w_valid,
    input  logic                    mst_w_ready,
    input  logic [1:0]              mst_b_resp,
    input  logic                    mst_b_valid,
    output logic                    mst_b_ready,
    output logic [ADDR_WIDTH-1:0]   mst_ar_addr,
    output logic [2:0]              mst_ar_prot,
    output logic                    mst_ar_valid,
    input  logic                    mst_ar_ready,
    input  logic [DATA_WIDTH-1:0]   mst_r_data,
    input  logic [1:0]              mst_r_resp,
    input  logic                    mst_r_valid,
    output logic                    mst_r_ready
);

    localparam int CW = $clog2(MAX_TRANS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TRANS);

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t        state;
    logic [CW-1:0] aw_out, w_out, r_out;
    logic          aw_hold, w_hold, ar_hold;

    logic aw_admit, w_admit, ar_admit;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic drained;

    // Payload and response channels are pure wires.
    assign mst_aw_addr = slv_aw_addr;
    assign mst_aw_prot = slv_aw_prot;
    assign mst_w_data  = slv_w_data;
    assign mst_w_strb  = slv_w_strb;
    assign mst_ar_addr = slv_ar_addr;
    assign mst_ar_prot = slv_ar_prot;
    assign slv_b_resp  = mst_b_resp;
    assign slv_b_valid = mst_b_valid;
    assign mst_b_ready = slv_b_ready;
    assign slv_r_data  = mst_r_data;
    assign slv_r_resp  = mst_r_resp;
    assign slv_r_valid = mst_r_valid;
    assign mst_r_ready = slv_r_ready;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_admit = 1'b0;
        case (state)
            RUN:     w_admit = (w_out < MAX_CNT);
            DRAIN:   w_admit = (w_out < aw_out);
            default: w_admit = 1'b0;
        endcase
        w_admit  = w_admit | w_hold;
        aw_admit = aw_hold | ((state == RUN) && (aw_out < MAX_CNT));
        ar_admit = ar_hold | ((state == RUN) && (r_out < MAX_CNT));
    end

    assign mst_aw_valid = ~rst & slv_aw_valid & aw_admit;
    assign slv_aw_ready = ~rst & mst_aw_ready & aw_admit;
    assign mst_w_valid  = ~rst & slv_w_valid  & w_admit;
    assign slv_w_ready  = ~rst & mst_w_ready  & w_admit;
    assign mst_ar_valid = ~rst & slv_ar_valid & ar_admit;
    assign slv_ar_ready = ~rst & mst_ar_ready & ar_admit;

    assign aw_hs = mst_aw_valid & mst_aw_ready;
    assign w_hs  = mst_w_valid  & mst_w_ready;
    assign ar_hs = mst_ar_valid & mst_ar_ready;
    assign b_hs  = mst_b_valid  & slv_b_ready;
    assign r_hs  = mst_r_valid  & slv_r_ready;

    assign drained = (aw_out == '0) && (w_out == '0) && (r_out == '0) &&
                     !aw_hold && !w_hold && !ar_hold;

    // A decrement on an empty counter is a fabric protocol error; it simply stays at zero.
    function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cur,
                                                 input logic inc, input logic dec);
        if (inc && !dec)                    return cur + 1'b1;
        else if (dec && !inc && cur != '0) return cur - 1'b1;
        else                                return cur;
    endfunction

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pause_ack <= 1'b0;
            aw_out    <= '0;
            w_out     <= '0;
            r_out     <= '0;
            aw_hold   <= 1'b0;
            w_hold    <= 1'b0;
            ar_hold   <= 1'b0;
        end else begin
            aw_out <= count_next(aw_out, aw_hs, b_hs);
            w_out  <= count_next(w_out,  w_hs,  b_hs);
            r_out  <= count_next(r_out,  ar_hs, r_hs);

            // A presented but unaccepted request stays forwarded until it handshakes.
            if (aw_hs)                            aw_hold <= 1'b0;
            else if (mst_aw_valid && !mst_aw_ready) aw_hold <= 1'b1;
            if (w_hs)                             w_hold  <= 1'b0;
            else if (mst_w_valid && !mst_w_ready)   w_hold  <= 1'b1;
            if (ar_hs)                            ar_hold <= 1'b0;
            else if (mst_ar_valid && !mst_ar_ready) ar_hold <= 1'b1;

            case (state)
                RUN: begin
                    if (pause_req) state <= DRAIN;
                    pause_ack <= 1'b0;
                end
                DRAIN: begin
                    if (!pause_req) begin
                        state     <= RUN;
                        pause_ack <= 1'b0;
                    end else if (drained) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end else begin
                        pause_ack <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= RUN;
                        pause_ack <= 1'b0;
                    end else begin
                        pause_ack <= 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    pause_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adam_axil_pause_drain.sv
// Directed self-checking bench for adam_axil_pause_drain (MAX_TRANS=4).
module tb_adam_axil_pause_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_req, pause_ack;
    logic [31:0] slv_aw_addr, slv_w_data, slv_ar_addr, slv_r_data;
    logic [2:0]  slv_aw_prot, slv_ar_prot;
    logic [3:0]  slv_w_strb;
    logic        slv_aw_valid, slv_aw_ready, slv_w_valid, slv_w_ready;
    logic [1:0]  slv_b_resp, slv_r_resp;
    logic        slv_b_valid, slv_b_ready, slv_ar_valid, slv_ar_ready, slv_r_valid, slv_r_ready;
    logic [31:0] mst_aw_addr, mst_w_data, mst_ar_addr, mst_r_data;
    logic [2:0]  mst_aw_prot, mst_ar_prot;
    logic [3:0]  mst_w_strb;
    logic        mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_ready;
    logic [1:0]  mst_b_resp, mst_r_resp;
    logic        mst_b_valid, mst_b_ready, mst_ar_valid, mst_ar_ready, mst_r_valid, mst_r_ready;

    int tests = 0;
    int fails = 0;

    adam_axil_pause_drain #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .slv_aw_addr(slv_aw_addr), .slv_aw_prot(slv_aw_prot), .slv_aw_valid(slv_aw_valid),
        .slv_aw_ready(slv_aw_ready), .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb),
        .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready), .slv_b_resp(slv_b_resp),
        .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready), .slv_ar_addr(slv_ar_addr),
        .slv_ar_prot(slv_ar_prot), .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_valid(slv_r_valid),
        .slv_r_ready(slv_r_ready),
        .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot), .mst_aw_valid(mst_aw_valid),
        .mst_aw_ready(mst_aw_ready), .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb),
        .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready), .mst_b_resp(mst_b_resp),
        .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready), .mst_ar_addr(mst_ar_addr),
        .mst_ar_prot(mst_ar_prot), .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_valid(mst_r_valid),
        .mst_r_ready(mst_r_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pause_req = 1'b0;
        slv_aw_addr = 32'h0; slv_aw_prot = 3'b0; slv_aw_valid = 1'b1;
        slv_w_data = 32'h0; slv_w_strb = 4'h0; slv_w_valid = 1'b1;
        slv_ar_addr = 32'h0; slv_ar_prot = 3'b0; slv_ar_valid = 1'b1;
        slv_b_ready = 1'b1; slv_r_ready = 1'b1;
        mst_aw_ready = 1'b1; mst_w_ready = 1'b1; mst_ar_ready = 1'b1;
        mst_b_resp = 2'b00; mst_b_valid = 1'b0;
        mst_r_data = 32'h0; mst_r_resp = 2'b00; mst_r_valid = 1'b0;

        // Reset: request channels blocked even with valid/ready both high.
        step(); step();
        check("rst_mst_aw_valid", mst_aw_valid, 0);
        check("rst_slv_aw_ready", slv_aw_ready, 0);
        check("rst_mst_w_valid",  mst_w_valid,  0);
        check("rst_slv_ar_ready", slv_ar_ready, 0);
        check("rst_ack", pause_ack, 0);
        rst = 1'b0;
        slv_aw_valid = 1'b0; slv_w_valid = 1'b0; slv_ar_valid = 1'b0;
        mst_aw_ready = 1'b0; mst_w_ready = 1'b0; mst_ar_ready = 1'b0;
        settle();
        check("post_rst_aw_out", dut.aw_out, 0);
        check("post_rst_r_out", dut.r_out, 0);

        // Reads: four back-to-back ARs pass, the fifth waits for the first R.
        mst_ar_ready = 1'b1; slv_ar_valid = 1'b1;
        slv_ar_addr = 32'h1000_0040; slv_ar_prot = 3'b010;
        settle();
        check("ar_addr_pass", mst_ar_addr, 32'h1000_0040);
        check("ar_prot_pass", mst_ar_prot, 3'b010);
        for (int i = 0; i < 4; i++) begin
            check("ar_admit", slv_ar_ready, 1);
            step();
        end
        check("ar_limit_ready", slv_ar_ready, 0);
        check("ar_limit_valid", mst_ar_valid, 0);
        step();
        check("ar_limit_hold", slv_ar_ready, 0);
        mst_r_valid = 1'b1; mst_r_data = 32'hCAFE_0001; mst_r_resp = 2'b10;
        settle();
        check("r_valid_pass", slv_r_valid, 1);
        check("r_data_pass", slv_r_data, 32'hCAFE_0001);
        check("r_resp_pass", slv_r_resp, 2'b10);
        check("ar_before_r", slv_ar_ready, 0);
        step();
        mst_r_valid = 1'b0;
        settle();
        check("ar_after_r", slv_ar_ready, 1);
        step();
        slv_ar_valid = 1'b0; mst_ar_ready = 1'b0; mst_r_valid = 1'b1;
        repeat (4) step();
        mst_r_valid = 1'b0;
        settle();
        check("reads_done_r_out", dut.r_out, 0);

        // Drain: two writes outstanding, B held back, new AW blocked.
        slv_aw_valid = 1'b1; slv_w_valid = 1'b1; mst_aw_ready = 1'b1; mst_w_ready = 1'b1;
        slv_w_data = 32'hDEAD_BEEF; slv_w_strb = 4'hA;
        settle();
        check("w_data_pass", mst_w_data, 32'hDEAD_BEEF);
        check("w_strb_pass", mst_w_strb, 4'hA);
        check("aw_run_ready", slv_aw_ready, 1);
        check("w_run_ready", slv_w_ready, 1);
        step(); step();
        slv_aw_valid = 1'b0; slv_w_valid = 1'b0; pause_req = 1'b1;
        step();
        slv_aw_valid = 1'b1;
        settle();
        check("drain_aw_blocked", mst_aw_valid, 0);
        check("drain_aw_ready", slv_aw_ready, 0);
        check("drain_w_not_owed", slv_w_ready, 0);
        repeat (8) step();
        check("drain_ack_wait", pause_ack, 0);
        mst_b_valid = 1'b1; mst_b_resp = 2'b01;
        settle();
        check("b_valid_pass", slv_b_valid, 1);
        check("b_resp_pass", slv_b_resp, 2'b01);
        step(); step();
        mst_b_valid = 1'b0;
        settle();
        check("drain_ack_at_last_b", pause_ack, 0);
        check("drain_aw_out", dut.aw_out, 0);
        step();
        check("drain_ack_rise", pause_ack, 1);
        check("paused_aw_blocked", mst_aw_valid, 0);
        pause_req = 1'b0;
        step();
        check("resume_ack", pause_ack, 0);
        check("resume_aw_admit", mst_aw_valid, 1);
        slv_aw_valid = 1'b0; mst_aw_ready = 1'b0; mst_w_ready = 1'b0;
        settle();

        // Hold: a stalled AW stays forwarded across the pause request.
        slv_aw_valid = 1'b1; slv_aw_addr = 32'h2000_0000;
        settle();
        check("hold_aw_valid", mst_aw_valid, 1);
        step();
        pause_req = 1'b1;
        step();
        check("hold_in_drain", mst_aw_valid, 1);
        step();
        check("hold_still", mst_aw_valid, 1);
        check("hold_ack", pause_ack, 0);
        mst_aw_ready = 1'b1;
        settle();
        check("hold_aw_ready", slv_aw_ready, 1);
        step();
        slv_aw_valid = 1'b0; mst_aw_ready = 1'b0;
        settle();
        check("hold_aw_out", dut.aw_out, 1);
        slv_w_valid = 1'b1; mst_w_ready = 1'b1;
        settle();
        check("hold_w_owed", slv_w_ready, 1);
        step();
        slv_w_valid = 1'b0;
        settle();
        check("hold_w_no_extra", slv_w_ready, 0);
        check("hold_ack_before_b", pause_ack, 0);
        mst_b_valid = 1'b1;
        step();
        mst_b_valid = 1'b0;
        settle();
        check("hold_ack_at_b", pause_ack, 0);
        step();
        check("hold_ack_rise", pause_ack, 1);
        pause_req = 1'b0; mst_w_ready = 1'b0;
        step();
        check("hold_resume", pause_ack, 0);

        // Owed W: AW accepted in RUN, its W delivered during DRAIN.
        slv_aw_valid = 1'b1; mst_aw_ready = 1'b1;
        step();
        slv_aw_valid = 1'b0; mst_aw_ready = 1'b0; pause_req = 1'b1;
        step();
        slv_w_valid = 1'b1; mst_w_ready = 1'b1;
        settle();
        check("owed_w_valid", mst_w_valid, 1);
        check("owed_w_ready", slv_w_ready, 1);
        step();
        slv_w_valid = 1'b0;
        step(); step();
        check("owed_ack_wait", pause_ack, 0);
        mst_b_valid = 1'b1;
        step();
        mst_b_valid = 1'b0;
        settle();
        check("owed_ack_at_b", pause_ack, 0);
        step();
        check("owed_ack_rise", pause_ack, 1);
        pause_req = 1'b0; mst_w_ready = 1'b0;
        step();

        // Idle pause/resume timing.
        pause_req = 1'b1;
        step();
        check("idle_ack_e1", pause_ack, 0);
        slv_ar_valid = 1'b1; mst_ar_ready = 1'b1;
        settle();
        check("idle_ar_gated", mst_ar_valid, 0);
        step();
        check("idle_ack_e2", pause_ack, 1);
        repeat (3) step();
        check("idle_ack_held", pause_ack, 1);
        pause_req = 1'b0;
        step();
        check("idle_ack_fall", pause_ack, 0);
        check("idle_ar_fwd", mst_ar_valid, 1);
        check("idle_ar_ready", slv_ar_ready, 1);
        step();
        slv_ar_valid = 1'b0; mst_ar_ready = 1'b0; mst_r_valid = 1'b1;
        step();
        mst_r_valid = 1'b0;
        settle();
        check("idle_r_out", dut.r_out, 0);

        // Reset in the middle of a drain with two AWs outstanding.
        slv_aw_valid = 1'b1; mst_aw_ready = 1'b1;
        step(); step();
        slv_aw_valid = 1'b0; pause_req = 1'b1;
        step();
        check("mid_aw_out", dut.aw_out, 2);
        rst = 1'b1;
        step();
        rst = 1'b0; mst_aw_ready = 1'b0;
        settle();
        check("mid_rst_aw_out", dut.aw_out, 0);
        check("mid_rst_w_out", dut.w_out, 0);
        check("mid_rst_ack", pause_ack, 0);
        slv_ar_valid = 1'b1; mst_ar_ready = 1'b1;
        settle();
        check("mid_rst_run", mst_ar_valid, 1);
        slv_ar_valid = 1'b0; mst_ar_ready = 1'b0;
        step();
        check("mid_ack_e1", pause_ack, 0);
        step();
        check("mid_ack_e2", pause_ack, 1);
        pause_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
